// File: rtl/instr_mem_loader_if.sv
// Byte-stream input, memory write port and status bundle of the instruction-memory loader.
// checksum exists only when LOADER_CHECKSUM_EN is defined.
interface instr_mem_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;
  logic        write_en;
  logic [31:0] write_addr;
  logic [31:0] data_in;
  logic        cpu_hold;
  logic        done;
  logic [16:0] word_count;
  logic        err_overflow;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  // master: program source / supervisor side
  modport master (
    output start, byte_valid, byte_data, byte_last,
    input  byte_ready, write_en, write_addr, data_in, cpu_hold, done,
           word_count, err_overflow
`ifdef LOADER_CHECKSUM_EN
    , input checksum
`endif
  );

  modport slave (
    input  start, byte_valid, byte_data, byte_last,
    output byte_ready, write_en, write_addr, data_in, cpu_hold, done,
           word_count, err_overflow
`ifdef LOADER_CHECKSUM_EN
    , output checksum
`endif
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Packs a big-endian byte stream into 32-bit words and writes them to instruction memory.
// Optional LOADER_CHECKSUM_EN adds a running mod-2^32 sum of written words.
//
// state | meaning
// IDLE  | waiting for start, CPU free
// RECV  | accepting bytes into the current word
// WRITE | one-cycle memory write (or drop on overflow)
// DONE  | load finished, CPU released
module instr_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned MAX_WORDS = 65536
) (
  input  logic               clk,
  input  logic               rst,
  instr_mem_loader_if.slave  bus
);

  localparam logic [16:0] MAX_WC = 17'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t      state, state_d;
  logic        byte_ready, byte_ready_d;
  logic        write_en, write_en_d;
  logic [31:0] write_addr, write_addr_d;
  logic [31:0] data_in, data_in_d;
  logic        cpu_hold, cpu_hold_d;
  logic        done, done_d;
  logic [16:0] word_count, word_count_d;
  logic        err_overflow, err_overflow_d;
  logic [1:0]  idx, idx_d;
  logic [31:0] word_buf, word_buf_d;
  logic        last_seen, last_seen_d;
  logic [31:0] assembled;
  logic [4:0]  shamt;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum, checksum_d;
`endif

  // lane (3 - idx) gives big-endian packing; ~idx == 3 - idx for 2 bits
  assign shamt     = {~idx, 3'b000};
  assign assembled = word_buf | ({24'b0, bus.byte_data} << shamt);

  always_comb begin
    state_d        = state;
    byte_ready_d   = byte_ready;
    write_en_d     = 1'b0;
    write_addr_d   = write_addr;
    data_in_d      = data_in;
    cpu_hold_d     = cpu_hold;
    done_d         = done;
    word_count_d   = word_count;
    err_overflow_d = err_overflow;
    idx_d          = idx;
    word_buf_d     = word_buf;
    last_seen_d    = last_seen;
`ifdef LOADER_CHECKSUM_EN
    checksum_d     = checksum;
`endif

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d        = RECV;
          byte_ready_d   = 1'b1;
          cpu_hold_d     = 1'b1;
          done_d         = 1'b0;
          word_count_d   = 17'd0;
          err_overflow_d = 1'b0;
          write_addr_d   = BASE_ADDR;
          idx_d          = 2'd0;
          word_buf_d     = 32'd0;
          last_seen_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          checksum_d     = 32'd0;
`endif
        end
      end

      RECV: begin
        if (bus.byte_valid && byte_ready) begin
          idx_d      = idx + 2'd1;
          word_buf_d = assembled;
          if (idx == 2'd3 || bus.byte_last) begin
            state_d      = WRITE;
            byte_ready_d = 1'b0;
            data_in_d    = assembled;
            last_seen_d  = bus.byte_last;
            write_en_d   = (word_count < MAX_WC);
          end
        end
      end

      WRITE: begin
        if (write_en) begin
          write_addr_d = write_addr + 32'd1;
          word_count_d = word_count + 17'd1;
`ifdef LOADER_CHECKSUM_EN
          checksum_d   = checksum + data_in;
`endif
        end else begin
          err_overflow_d = 1'b1;
        end
        idx_d      = 2'd0;
        word_buf_d = 32'd0;
        if (last_seen) begin
          state_d      = DONE;
          byte_ready_d = 1'b0;
          cpu_hold_d   = 1'b0;
          done_d       = 1'b1;
        end else begin
          state_d      = RECV;
          byte_ready_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      byte_ready   <= 1'b0;
      write_en     <= 1'b0;
      write_addr   <= BASE_ADDR;
      data_in      <= 32'd0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      word_count   <= 17'd0;
      err_overflow <= 1'b0;
      idx          <= 2'd0;
      word_buf     <= 32'd0;
      last_seen    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum     <= 32'd0;
`endif
    end else begin
      state        <= state_d;
      byte_ready   <= byte_ready_d;
      write_en     <= write_en_d;
      write_addr   <= write_addr_d;
      data_in      <= data_in_d;
      cpu_hold     <= cpu_hold_d;
      done         <= done_d;
      word_count   <= word_count_d;
      err_overflow <= err_overflow_d;
      idx          <= idx_d;
      word_buf     <= word_buf_d;
      last_seen    <= last_seen_d;
`ifdef LOADER_CHECKSUM_EN
      checksum     <= checksum_d;
`endif
    end
  end

  assign bus.byte_ready   = byte_ready;
  assign bus.write_en     = write_en;
  assign bus.write_addr   = write_addr;
  assign bus.data_in      = data_in;
  assign bus.cpu_hold     = cpu_hold;
  assign bus.done         = done;
  assign bus.word_count   = word_count;
  assign bus.err_overflow = err_overflow;
`ifdef LOADER_CHECKSUM_EN
  assign bus.checksum     = checksum;
`endif

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer-side companion to the instruction memory. Drives the memory's synchronous write port: write enable, 32-bit write address and 32-bit write data.
- Receives a program as a byte stream over a valid/ready handshake. Packs each 4 bytes big-endian into a word and writes words to consecutive word addresses starting at BASE_ADDR.
- Holds the CPU while a load is in progress and releases it with a done flag.

Parameters:
- BASE_ADDR, 0, word address of the first instruction written.
- MAX_WORDS, 65536, maximum words per load; matches the memory's 16-bit word index.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset; sampled on posedge clk.
- start  input  1  one-cycle pulse; begins a load (honoured in IDLE and DONE only).
- byte_valid  input  1  byte_data/byte_last are valid.
- byte_data  input  8  program byte.
- byte_last  input  1  marks the final byte of the program; qualified by byte_valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- write_en  output  1  memory write strobe, one cycle per word.
- write_addr  output  32  memory word address.
- data_in  output  32  memory write data.
- cpu_hold  output  1  high while loading; CPU must stall or stay in reset.
- done  output  1  high in DONE state.
- word_count  output  17  words written in the current or last load.
- err_overflow  output  1  sticky; a word was dropped because MAX_WORDS was reached.

Behaviour:
- Byte transfer: a byte is accepted on a posedge where byte_valid=1 and byte_ready=1. byte_ready is registered and depends only on state, never on byte_valid.
- Reset (rst=0 at posedge): state=IDLE; byte_ready=0, write_en=0, write_addr=BASE_ADDR, data_in=0, cpu_hold=0, done=0, word_count=0, err_overflow=0; byte index=0; any partial word is discarded.
  - Reset mid-load aborts the load; no further write_en pulses occur.
- States:
  - IDLE: waiting.
    - start=1 -> RECV; cpu_hold=1, word_count=0, err_overflow=0, write_addr=BASE_ADDR, byte index=0.
  - RECV: byte_ready=1. Each accepted byte goes to lane (3 - index): byte 0 -> bits 31:24, byte 3 -> bits 7:0. Index then increments.
    - On acceptance of the 4th byte, or of any byte with byte_last=1 -> WRITE.
    - If byte_last arrives early, the unfilled lanes are zero.
  - WRITE: exactly one cycle. byte_ready=0.
    - If word_count < MAX_WORDS: write_en=1, data_in=assembled word, and write_addr holds its value for this cycle. On exit, write_addr+1 and word_count+1.
    - Otherwise: write_en=0, err_overflow<=1, word dropped.
    - Next state is DONE if the word contained byte_last, else RECV with index=0.
  - DONE: done=1, cpu_hold=0, byte_ready=0. word_count and err_overflow hold.
    - start=1 -> RECV (new load, same init as from IDLE).
- Latency: final byte of a word accepted at edge N -> write_en high for the cycle following edge N, sampled by memory at edge N+1.
  - Back-to-back words: at most 4 bytes per 5 cycles.
- start while in RECV/WRITE is ignored.
- A byte with byte_valid=0 is never consumed; byte_last is ignored without byte_valid.
- write_addr increments mod 2^32.
- An empty load is impossible; the first accepted byte always produces a word.

Optional Feature:
- LOADER_CHECKSUM_EN defined:
  - Adds output checksum[31:0], the mod-2^32 sum of all data_in values actually written (dropped words excluded).
  - Cleared to 0 on reset and on start; updated in the same cycle as write_en; holds in DONE.
- Undefined: checksum port and adder absent; all other behaviour identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles mid-RECV after 2 bytes -> all outputs at reset values. Then a start plus 4 bytes writes a full fresh word; no stale lanes.
- Single word: start, bytes 0x00,0x80,0x80,0x20 with last on 4th -> one write_en pulse, write_addr=0, data_in=0x00808020. Then done=1, cpu_hold=0, word_count=1.
- Partial word: bytes 0xAB,0xCD with byte_last on 2nd -> data_in=0xABCD0000, one write, DONE.
- Stream with gaps: 3 words (12 bytes) with byte_valid low on random cycles -> writes at addresses 0,1,2 in order with correct data. byte_ready=0 during each WRITE cycle; word_count=3.
- Overflow with MAX_WORDS=2: 3 words -> 2 writes, third dropped (write_en stays 0), err_overflow=1, word_count=2. A following start clears err_overflow.
- Checksum (LOADER_CHECKSUM_EN): words 0xFFFFFFFF and 0x00000002 -> checksum=0x00000001 in DONE; a second start clears it to 0.
